hps_peak_search: RTL and testbench

Harmonic-product-spectrum peak search stage, directly downstream of the HPS bin counter (`clock_div`).
- Each time the counter's `count` output advances, this block takes the new value as base bin k.
- It reads spectrum magnitudes at bins k, 2k, … HARMONICS·k from the magnitude RAM and multiplies them.
- It keeps the running maximum product across the frame and publishes the winning bin as the pitch estimate.

---
 rtl/hps_peak_search.sv | 161 ++++++++++++++++
 tb/tb_hps_peak_search.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hps_peak_search.sv
// rtl/hps_peak_search.sv - harmonic-product-spectrum peak search over base bins
module hps_peak_search #(
    parameter int HARMONICS  = 3,
    parameter int ADDR_WIDTH = 12,
    parameter int MAG_WIDTH  = 16,
    parameter int NUM_BINS   = 1024
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [ADDR_WIDTH-1:0]           base_bin,
    input  logic                            frame_start,
    output logic [ADDR_WIDTH-1:0]           mag_addr,
    output logic                            mag_rd_en,
    input  logic [MAG_WIDTH-1:0]            mag_rdata,
    output logic [ADDR_WIDTH-1:0]           peak_bin,
    output logic [MAG_WIDTH*HARMONICS-1:0]  peak_mag,
    output logic                            peak_valid,
    output logic                            busy,
    output logic                            overrun
);

    localparam int PROD_WIDTH = MAG_WIDTH * HARMONICS;
    localparam int AW2        = ADDR_WIDTH + 2;
    localparam int HW         = $clog2(HARMONICS + 2);
    localparam logic [AW2-1:0]        NUM_BINS_W = AW2'(NUM_BINS);
    localparam logic [ADDR_WIDTH-1:0] LAST_BIN   = ADDR_WIDTH'((NUM_BINS - 1) / HARMONICS);
    localparam logic [HW-1:0]         H_LAST     = HW'(HARMONICS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_CMP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   last_bin_q;
    logic [ADDR_WIDTH-1:0]   k_q;
    logic [AW2-1:0]          addr_acc_q;
    logic [HW-1:0]           h_q;
    logic [PROD_WIDTH-1:0]   product_q;
    logic [PROD_WIDTH-1:0]   run_max_q;
    logic [ADDR_WIDTH-1:0]   run_bin_q;
    logic [ADDR_WIDTH-1:0]   mag_addr_q;
    logic                    mag_rd_en_q;
    logic [ADDR_WIDTH-1:0]   peak_bin_q;
    logic [PROD_WIDTH-1:0]   peak_mag_q;
    logic                    peak_valid_q;
    logic                    busy_q;
    logic                    overrun_q;

    logic                    change;
    logic                    base_in_range;
    logic [AW2-1:0]          addr_next_d;
    logic                    next_in_range;
    logic [PROD_WIDTH-1:0]   product_d;
    logic [PROD_WIDTH-1:0]   run_max_d;
    logic [ADDR_WIDTH-1:0]   run_bin_d;

    // Change detect, next harmonic address, harmonic multiply and max selection.
    always_comb begin
        change        = (base_bin != last_bin_q);
        base_in_range = ({2'b00, base_bin} < NUM_BINS_W);
        addr_next_d   = addr_acc_q + {2'b00, k_q};
        next_in_range = (addr_next_d < NUM_BINS_W);
        // Out-of-range harmonics zero the product regardless of what the RAM returns.
        product_d     = (addr_acc_q < NUM_BINS_W) ? product_q * mag_rdata : '0;
        run_max_d     = run_max_q;
        run_bin_d     = run_bin_q;
        if (product_q > run_max_q) begin
            run_max_d = product_q;
            run_bin_d = k_q;
        end
    end

    // Peak-search FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_bin_q   <= '0;
            k_q          <= '0;
            addr_acc_q   <= '0;
            h_q          <= '0;
            product_q    <= '0;
            run_max_q    <= '0;
            run_bin_q    <= '0;
            mag_addr_q   <= '0;
            mag_rd_en_q  <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            last_bin_q   <= base_bin;
            peak_valid_q <= 1'b0;
            mag_rd_en_q  <= 1'b0;
            overrun_q    <= change && (state_q != S_IDLE);
            if (frame_start && (state_q != S_CMP)) begin
                run_max_q <= '0;
                run_bin_q <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (change && (base_bin != '0)) begin
                        k_q         <= base_bin;
                        addr_acc_q  <= {2'b00, base_bin};
                        h_q         <= HW'(1);
                        product_q   <= PROD_WIDTH'(1);
                        mag_addr_q  <= base_bin;
                        mag_rd_en_q <= base_in_range;
                        busy_q      <= 1'b1;
                        state_q     <= S_READ;
                    end
                end
                S_READ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    product_q  <= product_d;
                    addr_acc_q <= addr_next_d;
                    h_q        <= h_q + HW'(1);
                    if (h_q == H_LAST) begin
                        state_q <= S_CMP;
                    end else begin
                        mag_addr_q  <= addr_next_d[ADDR_WIDTH-1:0];
                        mag_rd_en_q <= next_in_range;
                        state_q     <= S_READ;
                    end
                end
                S_CMP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (k_q == LAST_BIN) begin
                        peak_bin_q   <= run_bin_d;
                        peak_mag_q   <= run_max_d;
                        peak_valid_q <= 1'b1;
                        run_max_q    <= '0;
                        run_bin_q    <= '0;
                    end else if (frame_start) begin
                        run_max_q <= '0;
                        run_bin_q <= '0;
                    end else begin
                        run_max_q <= run_max_d;
                        run_bin_q <= run_bin_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mag_addr   = mag_addr_q;
    assign mag_rd_en  = mag_rd_en_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign peak_valid = peak_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_hps_peak_search.sv
// tb/tb_hps_peak_search.sv - self-checking bench for hps_peak_search
module tb_hps_peak_search;

    localparam int H    = 3;
    localparam int AW   = 12;
    localparam int MW   = 16;
    localparam int NB   = 16;
    localparam int PW   = MW * H;
    localparam int LAST = (NB - 1) / H;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] base_bin = '0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] mag_addr;
    logic          mag_rd_en;
    logic [MW-1:0] mag_rdata = '0;
    logic [AW-1:0] peak_bin;
    logic [PW-1:0] peak_mag;
    logic          peak_valid;
    logic          busy;
    logic          overrun;

    int n_assert = 0;
    int n_fail   = 0;

    logic [MW-1:0] mem [NB];
    logic [AW-1:0] rd_q [$];
    int busy_cnt = 0;
    int pv_cnt   = 0;
    int ov_cnt   = 0;

    hps_peak_search #(
        .HARMONICS (H),
        .ADDR_WIDTH(AW),
        .MAG_WIDTH (MW),
        .NUM_BINS  (NB)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .base_bin   (base_bin),
        .frame_start(frame_start),
        .mag_addr   (mag_addr),
        .mag_rd_en  (mag_rd_en),
        .mag_rdata  (mag_rdata),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .peak_valid (peak_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    // RAM model with 1-cycle latency; garbage when not enabled.
    always @(posedge clock) begin
        if (mag_rd_en && (mag_addr < AW'(NB)))
            mag_rdata <= mem[mag_addr];
        else
            mag_rdata <= MW'($urandom);
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (mag_rd_en) rd_q.push_back(mag_addr);
        if (busy) busy_cnt++;
        if (peak_valid) pv_cnt++;
        if (overrun) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic put_bin(input int b, input int gap);
        base_bin = AW'(b);
        cyc(gap);
    endtask

    // Reference HPS value: product of magnitudes at k..H*k, zero if any is beyond the spectrum.
    function automatic logic [PW-1:0] hps(input int k);
        logic [PW-1:0] p;
        p = 1;
        for (int h = 1; h <= H; h++)
            p = (h * k < NB) ? p * mem[h * k] : '0;
        return p;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < NB; i++) mem[i] = '0;
    endtask

    // One frame of bins 1..LAST at FACTOR=8, checked against the argmax of hps().
    task automatic run_frame(input string tag);
        logic [PW-1:0] best;
        int best_bin;
        int pv0, ov0;
        best = '0;
        best_bin = 0;
        for (int k = 1; k <= LAST; k++)
            if (hps(k) > best) begin
                best = hps(k);
                best_bin = k;
            end
        pv0 = pv_cnt;
        ov0 = ov_cnt;
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        for (int k = 1; k <= LAST; k++) begin
            if (k == LAST) begin
                put_bin(k, 7);
                chk({tag, "_pv_early"}, 64'(peak_valid), 64'd0);
                cyc(1);
            end else begin
                put_bin(k, 8);
            end
        end
        chk({tag, "_pv_timing"}, 64'(peak_valid), 64'd1);
        chk({tag, "_peak_bin"}, 64'(peak_bin), 64'(best_bin));
        chk({tag, "_peak_mag"}, 64'(peak_mag), 64'(best));
        cyc(3);
        chk({tag, "_pv_count"}, 64'(pv_cnt - pv0), 64'd1);
        chk({tag, "_no_overrun"}, 64'(ov_cnt - ov0), 64'd0);
    endtask

    initial begin
        int pv0, ov0;
        clear_mem();
        cyc(3);
        chk("rst_mag_addr", 64'(mag_addr), 64'd0);
        chk("rst_rd_en", 64'(mag_rd_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_peak", 64'({peak_bin, peak_mag, peak_valid, overrun}), 64'd0);
        reset_n = 1'b1;
        cyc(2);

        // Single bin 2: reads 2,4,6, busy 7 cycles.
        mem[2] = 3; mem[4] = 5; mem[6] = 7;
        frame_start = 1'b1; cyc(1); frame_start = 1'b0;
        rd_q.delete(); busy_cnt = 0;
        put_bin(2, 10);
        chk("b2_nreads", 64'(rd_q.size()), 64'd3);
        chk("b2_rd0", 64'(rd_q[0]), 64'd2);
        chk("b2_rd1", 64'(rd_q[1]), 64'd4);
        chk("b2_rd2", 64'(rd_q[2]), 64'd6);
        chk("b2_busy_cycles", 64'(busy_cnt), 64'd7);

        // Bin 6: top harmonic 18 is out of range, no read, product 0.
        rd_q.delete();
        mem[12] = 100;
        put_bin(6, 10);
        chk("b6_nreads", 64'(rd_q.size()), 64'd2);
        chk("b6_rd0", 64'(rd_q[0]), 64'd6);
        chk("b6_rd1", 64'(rd_q[1]), 64'd12);

        // Bin 5 is LAST_BIN: publishes bin 2 with product 105.
        put_bin(5, 10);
        chk("pub_pv_count", 64'(pv_cnt), 64'd1);
        chk("pub_peak_bin", 64'(peak_bin), 64'd2);
        chk("pub_peak_mag", 64'(peak_mag), 64'd105);

        // Full frame with bin 4 the hand-computed winner: 3*3*3 = 27.
        clear_mem();
        mem[4] = 3; mem[8] = 3; mem[12] = 3;
        mem[1] = 2; mem[2] = 2; mem[3] = 2;
        run_frame("bin4");
        chk("bin4_hand_mag", 64'(peak_mag), 64'd27);

        // Tie between bins 3 and 4 keeps the lower bin.
        clear_mem();
        mem[3] = 2; mem[6] = 2; mem[9] = 2;
        mem[4] = 2; mem[8] = 2; mem[12] = 2;
        run_frame("tie");
        chk("tie_hand_bin", 64'(peak_bin), 64'd3);

        // Overrun: bin 7 arrives 3 cycles after bin 2 and is dropped.
        rd_q.delete();
        ov0 = ov_cnt;
        put_bin(2, 3);
        put_bin(7, 10);
        chk("ovr_pulse_count", 64'(ov_cnt - ov0), 64'd1);
        chk("ovr_nreads", 64'(rd_q.size()), 64'd3);
        chk("ovr_last_read", 64'(rd_q[2]), 64'd6);
        put_bin(3, 10);
        chk("ovr_next_nreads", 64'(rd_q.size()), 64'd6);
        chk("ovr_next_rd", 64'(rd_q[3]), 64'd3);

        // Async reset in the middle of WAIT.
        put_bin(4, 2);
        #1;
        reset_n = 1'b0;
        base_bin = '0;
        #1;
        chk("arst_mag_addr", 64'(mag_addr), 64'd0);
        chk("arst_rd_en", 64'(mag_rd_en), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_peak", 64'({peak_bin, peak_mag, peak_valid, overrun}), 64'd0);
        cyc(2);
        reset_n = 1'b1;
        pv0 = pv_cnt;
        cyc(20);
        chk("arst_no_pv", 64'(pv_cnt - pv0), 64'd0);

        // Randomised frames, first with full-width magnitudes.
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < NB; i++)
                mem[i] = MW'($urandom_range(0, (it == 0) ? 65535 : 40));
            run_frame($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
